ifetch_prefetch_buffer: RTL and testbench
=========================================

Name: ifetch_prefetch_buffer

Overview:
- Instruction-fetch front end directly upstream of the instruction cache; drives the cache's processor-side request port.
- Sequentially fetches 32-bit words from a fetch PC and buffers {pc, instr} pairs in a small FIFO for the core.
- Supports a core redirect (branch/jump) that flushes buffered words and discards any in-flight cache response.

Parameters:
DEPTH, 4, FIFO entries; power of two, >= 2
RESET_PC, 32'h0000_0000, fetch PC after reset; bits[1:0] must be 0

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  synchronous reset, active-high
redirect_valid  input  1  one-cycle request to restart fetch at redirect_pc
redirect_pc  input  32  new fetch address; bits[1:0] ignored, forced to 0
out_valid  output  1  head FIFO entry valid
out_ready  input  1  core accepts head entry when out_valid & out_ready
out_pc  output  32  PC of head entry
out_instr  output  32  instruction word of head entry
cache_valid  output  1  request to cache; held with cache_addr stable until cache_ready
cache_ready  input  1  one-cycle registered pulse from cache; cache_rdata valid that cycle
cache_addr  output  32  word address of outstanding request
cache_rdata  input  32  returned instruction word

Behaviour:
- Reset (synchronous, active-high): FSM=IDLE, cache_valid=0, count=0 (out_valid=0), fetch_pc=RESET_PC, discard=0. FIFO data contents don't-care. Reset mid-request drops cache_valid the next cycle. Any later cache_ready is ignored because the FSM is in IDLE.
- Outputs cache_valid and cache_addr are registered. cache_valid=1 exactly when FSM=REQ.
- FSM IDLE:
  - If no redirect and count < DEPTH: go to REQ, cache_addr <= fetch_pc.
  - cache_ready in IDLE is ignored.
- FSM REQ:
  - Hold cache_valid=1 and cache_addr stable until cache_ready=1.
  - On cache_ready:
    - If discard=0 and no redirect this cycle: push {cache_addr, cache_rdata}, fetch_pc <= fetch_pc + 4.
    - If discard=1 or redirect: drop the data.
    - In all cases: discard <= 0, go to IDLE.
- Post-ready gap: cache_valid is deasserted for at least one cycle after every sampled cache_ready (the IDLE cycle). The cache relies on this to close its transfer.
- At most one outstanding request; never cancel a request once cache_valid is high.
- Hit throughput: one word per 3 cycles (IDLE, REQ, REQ+ready). Misses extend REQ arbitrarily.
- FIFO:
  - Circular buffer with rd/wr pointers of $clog2(DEPTH) bits wrapping naturally; count is $clog2(DEPTH)+1 bits.
  - out_valid = (count != 0); out_pc/out_instr are combinational from the head entry.
  - Pop on out_valid & out_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Overflow is impossible: a request is issued only when count < DEPTH, and only one request is outstanding.
- Redirect (highest priority, sampled every cycle):
  - count <= 0, pointers <= 0; a coincident pop or push is void.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - In REQ with no cache_ready this cycle: discard <= 1, stay in REQ, keep the original cache_addr.
  - In REQ with cache_ready this cycle: data dropped, go to IDLE, discard stays 0.
  - In IDLE: remain in IDLE this cycle; the new PC is requested from the next IDLE evaluation.
  - A second redirect while discard=1 only updates fetch_pc.
- Arithmetic: fetch_pc increment is modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
- Latency: after reset deasserts with the cache hitting in 1 cycle, out_valid rises 3 cycles after the first IDLE cycle.

Test Plan:
- Sequential fetch: reset, RESET_PC=0, cache model hits (ready 1 cycle after valid) with rdata=addr^32'hA5A5_0000, out_ready=1 → out stream pc 0,4,8,12…; instr matches; cache_valid low ≥1 cycle between requests.
- Backpressure/full: out_ready=0 → exactly DEPTH=4 words buffered (pc 0..12), cache_valid stays 0 afterwards; raise out_ready → pc 0,4,8,12 popped in order, then fetch resumes at 16.
- Redirect during miss: cache stalls 10 cycles on addr 0x20; pulse redirect_pc=0x103 at stall cycle 3 → cache_addr holds 0x20 until ready, word dropped; next request is 0x100; first out_pc=0x100.
- Redirect coincident with cache_ready and with pop: FIFO holds 2 entries, out_ready=1 → out_valid=0 next cycle, returned word dropped, next request = redirect_pc.
- Wrap: redirect_pc=32'hFFFF_FFF8 → out_pc FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Reset mid-request: assert reset while in REQ → cache_valid=0 next cycle; stray cache_ready 2 cycles later produces no push; first post-reset request = RESET_PC.

Source files
------------

// File: rtl/ifetch_prefetch_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_prefetch_buffer_if
// Description : Core-side output stream and cache-side request bus of the
//               instruction prefetch buffer.
// Revision    : 1.0 - initial release
// ============================================================================
interface ifetch_prefetch_buffer_if;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        cache_valid;
    logic        cache_ready;
    logic [31:0] cache_addr;
    logic [31:0] cache_rdata;

    // Fetch-unit view: produces the instruction stream and drives the cache request.
    modport master (
        output out_valid,
        output out_pc,
        output out_instr,
        input  out_ready,
        output cache_valid,
        output cache_addr,
        input  cache_ready,
        input  cache_rdata
    );

    // Consumer/cache view.
    modport slave (
        input  out_valid,
        input  out_pc,
        input  out_instr,
        output out_ready,
        input  cache_valid,
        input  cache_addr,
        output cache_ready,
        output cache_rdata
    );
endinterface
`default_nettype wire

// File: rtl/ifetch_prefetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_prefetch_buffer
// Description : Sequential instruction prefetcher feeding a {pc, instr} FIFO,
//               with core redirect flush and in-flight response discard.
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_prefetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        redirect_valid,
    input  wire logic [31:0] redirect_pc,
    ifetch_prefetch_buffer_if.master bus
);

    localparam int                 c_PTR_W     = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]   c_DEPTH_CNT = (c_PTR_W + 1)'(DEPTH);
    localparam logic [0:0]         c_IDLE      = 1'b0;
    localparam logic [0:0]         c_REQ       = 1'b1;

    logic [0:0]         r_state;
    logic [31:0]        r_cache_addr;
    logic [31:0]        r_fetch_pc;
    logic               r_discard;
    logic [31:0]        r_mem_pc    [DEPTH];
    logic [31:0]        r_mem_instr [DEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W:0]   r_count;

    logic               w_rsp;
    logic               w_push;
    logic               w_pop;

    // A response is only meaningful while a request is outstanding.
    assign w_rsp  = (r_state == c_REQ) && bus.cache_ready;
    assign w_push = w_rsp && !r_discard && !redirect_valid;
    assign w_pop  = (r_count != '0) && bus.out_ready;

    assign bus.cache_valid = (r_state == c_REQ);
    assign bus.cache_addr  = r_cache_addr;
    assign bus.out_valid   = (r_count != '0);
    assign bus.out_pc      = r_mem_pc[r_rd_ptr];
    assign bus.out_instr   = r_mem_instr[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_IDLE;
            r_cache_addr <= RESET_PC;
            r_fetch_pc   <= RESET_PC;
            r_discard    <= 1'b0;
        end else begin
            if (redirect_valid) begin
                r_fetch_pc <= {redirect_pc[31:2], 2'b00};
            end else if (w_push) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end

            case (r_state)
                c_IDLE: begin
                    if (!redirect_valid && (r_count < c_DEPTH_CNT)) begin
                        r_state      <= c_REQ;
                        r_cache_addr <= r_fetch_pc;
                    end
                end
                c_REQ: begin
                    // A live request is never cancelled; a redirect only marks its data stale.
                    if (bus.cache_ready) begin
                        r_state   <= c_IDLE;
                        r_discard <= 1'b0;
                    end else if (redirect_valid) begin
                        r_discard <= 1'b1;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || redirect_valid) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pc[r_wr_ptr]    <= r_cache_addr;
            r_mem_instr[r_wr_ptr] <= bus.cache_rdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ifetch_prefetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifetch_prefetch_buffer
// Description : Directed self-checking bench with cache model and scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifetch_prefetch_buffer;

    localparam logic [31:0] c_XOR = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    ifetch_prefetch_buffer_if bus ();

    ifetch_prefetch_buffer #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q [$];
    logic [31:0] req_q [$];

    // Cache model: answers stall_lat cycles late for stall_addr, otherwise next cycle.
    logic        m_ready;
    logic [31:0] m_rdata;
    logic        stray_ready;
    int          wait_cnt;
    logic [31:0] stall_addr;
    int          stall_lat;

    assign bus.cache_ready = m_ready | stray_ready;
    assign bus.cache_rdata = m_rdata;

    always @(posedge clk) begin
        if (reset) begin
            m_ready  <= 1'b0;
            wait_cnt <= 0;
            m_rdata  <= 32'h0;
        end else if (bus.cache_valid && !m_ready) begin
            if (wait_cnt >= ((bus.cache_addr == stall_addr) ? stall_lat : 0)) begin
                m_ready  <= 1'b1;
                m_rdata  <= bus.cache_addr ^ c_XOR;
                wait_cnt <= 0;
            end else begin
                wait_cnt <= wait_cnt + 1;
            end
        end else begin
            m_ready <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        n_checks++;
        n_fail++;
        $error("FAIL %s: observed timeout expected event", tag);
    endtask

    // Bus monitor: request stability, post-ready gap, and request log.
    logic        mon_v;
    logic        mon_r;
    logic [31:0] mon_a;
    always @(negedge clk) begin
        if (reset) begin
            mon_v <= 1'b0;
            mon_r <= 1'b0;
            mon_a <= 32'h0;
        end else begin
            if (mon_v && !mon_r && bus.cache_valid)
                check("addr_stable", bus.cache_addr, mon_a);
            if (mon_v && mon_r)
                check("post_ready_gap", {31'b0, bus.cache_valid}, 32'h0);
            if (bus.cache_valid && !mon_v)
                req_q.push_back(bus.cache_addr);
            mon_v <= bus.cache_valid;
            mon_r <= bus.cache_ready;
            mon_a <= bus.cache_addr;
        end
    end

    // Pop n entries with out_ready held high, comparing against the scoreboard.
    task automatic stream(input int n, input string tag);
        int          got = 0;
        int          t   = 0;
        logic [31:0] exp;
        bus.out_ready = 1'b1;
        while (got < n && t < 200) begin
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    timeout_fail({tag, "_empty_scoreboard"});
                    exp = 32'h0;
                end else begin
                    exp = exp_q.pop_front();
                end
                check({tag, "_pc"}, bus.out_pc, exp);
                check({tag, "_instr"}, bus.out_instr, exp ^ c_XOR);
                got++;
            end
            if (got < n) begin
                @(negedge clk);
                t++;
            end
        end
        if (got < n) timeout_fail(tag);
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic wait_req(input int n, input string tag);
        int t = 0;
        while (req_q.size() < n && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (req_q.size() < n) timeout_fail(tag);
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

    initial begin
        int idle_hits;
        int cnt;
        int t;

        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        bus.out_ready  = 1'b0;
        stray_ready    = 1'b0;
        stall_addr     = 32'h0000_0001;
        stall_lat      = 0;

        // Reset state and first-word latency
        repeat (3) @(negedge clk);
        check("rst_out_valid", {31'b0, bus.out_valid}, 32'h0);
        check("rst_cache_valid", {31'b0, bus.cache_valid}, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        check("lat1_cache_valid", {31'b0, bus.cache_valid}, 32'h1);
        check("lat1_cache_addr", bus.cache_addr, 32'h0);
        @(negedge clk);
        check("lat2_out_valid", {31'b0, bus.out_valid}, 32'h0);
        @(negedge clk);
        check("lat3_out_valid", {31'b0, bus.out_valid}, 32'h1);
        check("lat3_out_pc", bus.out_pc, 32'h0);

        // Backpressure: FIFO fills to DEPTH and fetch stops
        repeat (12) @(negedge clk);
        idle_hits = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.cache_valid) idle_hits++;
        end
        check("full_no_fetch", 32'(idle_hits), 32'h0);
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
        stream(8, "seq");

        // Redirect during a miss on 0x20
        repeat (20) @(negedge clk);
        stall_addr = 32'h0000_0020;
        stall_lat  = 10;
        req_q.delete();
        do_redirect(32'h0000_0020);
        check("flush_out_valid", {31'b0, bus.out_valid}, 32'h0);
        wait_req(1, "miss_req");
        repeat (3) @(negedge clk);
        do_redirect(32'h0000_0103);
        check("miss_hold_valid", {31'b0, bus.cache_valid}, 32'h1);
        check("miss_hold_addr", bus.cache_addr, 32'h0000_0020);
        t = 0;
        while (!bus.cache_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!bus.cache_ready) timeout_fail("miss_ready");
        @(negedge clk);
        check("miss_dropped", {31'b0, bus.out_valid}, 32'h0);
        wait_req(2, "miss_next_req");
        if (req_q.size() >= 2) begin
            check("miss_req0", req_q[0], 32'h0000_0020);
            check("miss_req1", req_q[1], 32'h0000_0100);
        end
        stall_addr = 32'h0000_0001;
        exp_q.push_back(32'h0000_0100);
        exp_q.push_back(32'h0000_0104);
        stream(2, "post_miss");

        // Redirect coincident with cache_ready and a pop
        repeat (20) @(negedge clk);
        do_redirect(32'h0000_0200);
        cnt = 0;
        t   = 0;
        while (cnt < 3 && t < 200) begin
            @(negedge clk);
            t++;
            if (bus.cache_ready) cnt++;
        end
        if (cnt < 3) begin
            timeout_fail("coinc_ready");
        end else begin
            check("coinc_two_valid", {31'b0, bus.out_valid}, 32'h1);
            check("coinc_head_pc", bus.out_pc, 32'h0000_0200);
            redirect_valid = 1'b1;
            redirect_pc    = 32'h0000_0300;
            bus.out_ready  = 1'b1;
            @(negedge clk);
            redirect_valid = 1'b0;
            bus.out_ready  = 1'b0;
            check("coinc_flush", {31'b0, bus.out_valid}, 32'h0);
            req_q.delete();
            wait_req(1, "coinc_next_req");
            if (req_q.size() >= 1) check("coinc_req", req_q[0], 32'h0000_0300);
            exp_q.push_back(32'h0000_0300);
            stream(1, "coinc_out");
        end

        // PC wrap at the top of the address space
        repeat (20) @(negedge clk);
        do_redirect(32'hFFFF_FFF8);
        exp_q.push_back(32'hFFFF_FFF8);
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);
        stream(3, "wrap");

        // Reset in the middle of a request, then a stray ready
        repeat (20) @(negedge clk);
        stall_addr = 32'h0000_0400;
        stall_lat  = 10;
        req_q.delete();
        do_redirect(32'h0000_0400);
        wait_req(1, "rst_req");
        if (req_q.size() >= 1) check("rst_req_addr", req_q[0], 32'h0000_0400);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_cache_valid", {31'b0, bus.cache_valid}, 32'h0);
        check("rst_mid_out_valid", {31'b0, bus.out_valid}, 32'h0);
        @(negedge clk);
        reset       = 1'b0;
        stray_ready = 1'b1;
        @(negedge clk);
        stray_ready = 1'b0;
        check("stray_no_push", {31'b0, bus.out_valid}, 32'h0);
        check("post_rst_valid", {31'b0, bus.cache_valid}, 32'h1);
        check("post_rst_addr", bus.cache_addr, 32'h0000_0000);
        stall_addr = 32'h0000_0001;
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0004);
        stream(2, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
